// File: rtl/wb_sevenseg_master_pkg.sv
// Shared types for the Wishbone display self-test initiator.
// FSM states, bus request bundle and select constant.
package wb_sevenseg_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR,
    S_RD,
    S_CHK
  } state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
  } wb_req_t;

  localparam wb_req_t WB_IDLE = '0;

  function automatic wb_req_t wb_write(
    input logic [31:0] adr,
    input logic [31:0] dat
  );
    wb_req_t r;
    r.adr = adr;
    r.dat = dat;
    r.sel = WB_SEL_ALL;
    r.we  = 1'b1;
    r.cyc = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/wb_sevenseg_master_if.sv
// Wishbone classic bus bundle between the self-test
// initiator and a single-register responder.
interface wb_sevenseg_master_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [31:0] rdt;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (
    output adr, dat, sel, we, cyc, stb,
    input  rdt, ack
  );

  modport slave (
    input  adr, dat, sel, we, cyc, stb,
    output rdt, ack
  );
endinterface

// File: rtl/wb_period_timer.sv
// Reloadable down-counter pacing the gap between
// write/read pairs; holds at zero until reloaded.
module wb_period_timer #(
  parameter int           W    = 24,
  parameter logic [W-1:0] LOAD = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= LOAD;
    end else if (load) begin
      count <= LOAD;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/wb_sevenseg_master.sv
// Periodic write/readback/compare initiator for a
// single Wishbone register such as a display latch.
module wb_sevenseg_master
  import wb_sevenseg_master_pkg::*;
#(
  parameter logic [23:0] PERIOD  = 24'd10_000_000,
  parameter logic [31:0] ADDR    = 32'h0000_0000,
  parameter logic [31:0] INCR    = 32'd1,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic                  i_wb_clk,
  input  logic                  i_wb_rst_n,
  input  logic                  i_en,
  wb_sevenseg_master_if.master  wb,
  output logic [31:0]           o_count,
  output logic                  o_err,
  output logic                  o_busy
);

  localparam logic [23:0] PLOAD = PERIOD - 24'd1;
  localparam logic [7:0]  TLAST = TIMEOUT - 8'd1;

  state_t      state;
  wb_req_t     req;
  logic [7:0]  tcnt;
  logic [31:0] rdata;
  logic        tmr_zero;

  // Timer sits at PERIOD-1 outside WAIT, so every WAIT entry starts full.
  wb_period_timer #(
    .W    (24),
    .LOAD (PLOAD)
  ) u_timer (
    .clk   (i_wb_clk),
    .rst_n (i_wb_rst_n),
    .load  (state != S_WAIT),
    .dec   (state == S_WAIT),
    .zero  (tmr_zero)
  );

  always_ff @(posedge i_wb_clk) begin
    if (!i_wb_rst_n) begin
      state   <= S_IDLE;
      req     <= WB_IDLE;
      tcnt    <= '0;
      rdata   <= '0;
      o_count <= '0;
      o_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!i_en) begin
            state <= S_IDLE;
          end else if (tmr_zero) begin
            state <= S_WR;
            tcnt  <= '0;
            req   <= wb_write(ADDR, o_count);
          end
        end
        S_WR: begin
          if (wb.ack) begin
            state  <= S_RD;
            tcnt   <= '0;
            req.we <= 1'b0;
          end else if (tcnt == TLAST) begin
            state <= i_en ? S_WAIT : S_IDLE;
            req   <= WB_IDLE;
            o_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_RD: begin
          if (wb.ack) begin
            state <= S_CHK;
            rdata <= wb.rdt;
            req   <= WB_IDLE;
          end else if (tcnt == TLAST) begin
            state <= i_en ? S_WAIT : S_IDLE;
            req   <= WB_IDLE;
            o_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_CHK: begin
          if (rdata == o_count) o_count <= o_count + INCR;
          else                  o_err   <= 1'b1;
          state <= i_en ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wb.adr = req.adr;
  assign wb.dat = req.dat;
  assign wb.sel = req.sel;
  assign wb.we  = req.we;
  assign wb.cyc = req.cyc;
  assign wb.stb = req.cyc;
  assign o_busy = req.cyc;

endmodule

// File: tb/tb_wb_sevenseg_master.sv
// Directed bench: two initiators (INCR=1 and INCR=-1)
// against behavioural registered-ack responders.
module tb_wb_sevenseg_master;

  localparam logic [31:0] ADDR = 32'h0000_0040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, en2, use2;
  logic [31:0] count1, count2;
  logic        err1, err2, busy1, busy2;

  wb_sevenseg_master_if bus1 ();
  wb_sevenseg_master_if bus2 ();

  wb_sevenseg_master #(
    .PERIOD (24'd4), .ADDR (ADDR),
    .INCR (32'd1), .TIMEOUT (8'd8)
  ) dut (
    .i_wb_clk (clk), .i_wb_rst_n (rst_n), .i_en (en),
    .wb (bus1.master),
    .o_count (count1), .o_err (err1), .o_busy (busy1)
  );

  wb_sevenseg_master #(
    .PERIOD (24'd4), .ADDR (ADDR),
    .INCR (32'hFFFF_FFFF), .TIMEOUT (8'd8)
  ) dut2 (
    .i_wb_clk (clk), .i_wb_rst_n (rst_n), .i_en (en2),
    .wb (bus2.master),
    .o_count (count2), .o_err (err2), .o_busy (busy2)
  );

  // Responder 1: programmable latency, optional corrupt read, optional no-ack.
  logic [31:0] mem1;
  int          lat, lcnt, wcnt, rcnt;
  logic        no_ack, bad, rd_seen;

  assign bus1.rdt = bad ? 32'hDEAD_BEEF : mem1;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus1.ack <= 1'b0;
      lcnt <= 0; wcnt <= 0; rcnt <= 0;
      mem1 <= '0; rd_seen <= 1'b0;
    end else begin
      if (bus1.cyc && !bus1.we) rd_seen <= 1'b1;
      if (bus1.cyc && bus1.stb && !bus1.ack && !no_ack) begin
        if (lcnt == lat) begin
          bus1.ack <= 1'b1;
          lcnt <= 0;
          if (bus1.we) begin
            mem1 <= bus1.dat;
            wcnt <= wcnt + 1;
          end else begin
            rcnt <= rcnt + 1;
          end
        end else begin
          lcnt <= lcnt + 1;
        end
      end else begin
        bus1.ack <= 1'b0;
      end
    end
  end

  logic [31:0] mem2;
  assign bus2.rdt = mem2;

  always @(posedge clk) begin
    if (!rst_n) begin
      bus2.ack <= 1'b0;
      mem2 <= '0;
    end else begin
      bus2.ack <= bus2.cyc && bus2.stb && !bus2.ack;
      if (bus2.cyc && bus2.stb && !bus2.ack && bus2.we)
        mem2 <= bus2.dat;
    end
  end

  logic        cyc_m;
  logic [31:0] dat_m;
  assign cyc_m = use2 ? bus2.cyc : bus1.cyc;
  assign dat_m = use2 ? bus2.dat : bus1.dat;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_hi(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc_m) break;
    end
    check(tag, {31'd0, cyc_m}, 32'd1);
  endtask

  task automatic wait_lo(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!cyc_m) break;
      n++;
    end
    check(tag, {31'd0, cyc_m}, 32'd0);
  endtask

  task automatic wait_pair(input string tag,
                           output logic [31:0] wd);
    int k;
    wait_hi({tag, "_start"});
    wd = dat_m;
    wait_lo({tag, "_end"}, k);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] d;
  int          n;
  logic        hi_seen;

  initial begin
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; use2 = 1'b0;
    lat = 0; no_ack = 1'b0; bad = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_cyc",   {31'd0, bus1.cyc}, 32'd0);
    check("rst_stb",   {31'd0, bus1.stb}, 32'd0);
    check("rst_we",    {31'd0, bus1.we},  32'd0);
    check("rst_sel",   {28'd0, bus1.sel}, 32'd0);
    check("rst_adr",   bus1.adr, 32'd0);
    check("rst_dat",   bus1.dat, 32'd0);
    check("rst_count", count1, 32'd0);
    check("rst_err",   {31'd0, err1},  32'd0);
    check("rst_busy",  {31'd0, busy1}, 32'd0);

    // Normal traffic with a one-cycle registered-ack responder.
    en = 1'b1;
    rst_n = 1'b1;
    wait_hi("p1_start");
    check("p1_adr",  bus1.adr, ADDR);
    check("p1_sel",  {28'd0, bus1.sel}, 32'hF);
    check("p1_we",   {31'd0, bus1.we},  32'd1);
    check("p1_stb",  {31'd0, bus1.stb}, 32'd1);
    check("p1_dat",  bus1.dat, 32'd0);
    check("p1_busy", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check("p1_wr_hold", {30'd0, bus1.cyc, bus1.we}, 32'd3);
    @(negedge clk);
    check("p1_rd_b2b", {29'd0, bus1.cyc, bus1.stb, bus1.we}, 32'd6);
    @(negedge clk);
    check("p1_rd_hold", {31'd0, bus1.cyc}, 32'd1);
    @(negedge clk);
    check("p1_chk_idle", {31'd0, bus1.cyc}, 32'd0);
    @(negedge clk);
    check("p1_count", count1, 32'd1);
    check("p1_err",   {31'd0, err1}, 32'd0);
    check("p1_wacks", wcnt, 32'd1);
    check("p1_racks", rcnt, 32'd1);
    for (int i = 1; i < 10; i++) begin
      wait_pair("pn", d);
      check($sformatf("p%0d_dat", i + 1), d, i);
    end
    check("p10_count", count1, 32'd10);
    check("p10_err",   {31'd0, err1}, 32'd0);
    check("p10_wacks", wcnt, 32'd10);
    check("p10_racks", rcnt, 32'd10);

    // Corrupt readback.
    pulse_reset();
    bad = 1'b1;
    wait_pair("bad", d);
    check("bad_dat",   d, 32'd0);
    check("bad_err",   {31'd0, err1}, 32'd1);
    check("bad_count", count1, 32'd0);
    bad = 1'b0;
    wait_pair("bad2", d);
    check("bad2_dat",   d, 32'd0);
    check("bad2_count", count1, 32'd1);
    check("bad2_err",   {31'd0, err1}, 32'd1);

    // Responder never acks.
    no_ack = 1'b1;
    pulse_reset();
    wait_hi("to_start");
    wait_lo("to_end", n);
    check("to_len",   1 + n, 32'd8);
    check("to_err",   {31'd0, err1}, 32'd1);
    check("to_norrd", {31'd0, rd_seen}, 32'd0);
    check("to_count", count1, 32'd0);
    no_ack = 1'b0;
    wait_pair("to_retry", d);
    check("to_retry_dat",   d, 32'd0);
    check("to_retry_count", count1, 32'd1);

    // Enable dropped while the read is waiting for ack.
    lat = 3;
    pulse_reset();
    wait_hi("en_start");
    for (int i = 0; i < 50; i++) begin
      if (bus1.cyc && !bus1.we) break;
      @(negedge clk);
    end
    check("en_rd", {30'd0, bus1.cyc, bus1.we}, 32'd2);
    en = 1'b0;
    wait_lo("en_end", n);
    @(negedge clk);
    check("en_count", count1, 32'd1);
    check("en_err",   {31'd0, err1}, 32'd0);
    check("en_racks", rcnt, 32'd1);
    hi_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      hi_seen = hi_seen | bus1.cyc;
    end
    check("en_idle", {31'd0, hi_seen}, 32'd0);
    check("en_busy", {31'd0, busy1}, 32'd0);

    // Reset in the middle of a write.
    lat = 0;
    en = 1'b1;
    pulse_reset();
    wait_pair("rs1", d);
    bad = 1'b1;
    wait_pair("rs2", d);
    bad = 1'b0;
    check("rs_pre_count", count1, 32'd1);
    check("rs_pre_err",   {31'd0, err1}, 32'd1);
    wait_hi("rs_wr");
    rst_n = 1'b0;
    @(negedge clk);
    check("rs_bus",   {29'd0, bus1.cyc, bus1.stb, bus1.we}, 32'd0);
    check("rs_count", count1, 32'd0);
    check("rs_err",   {31'd0, err1}, 32'd0);
    rst_n = 1'b1;
    en = 1'b0;

    // Wrapping increment on the second instance.
    use2 = 1'b1;
    en2 = 1'b1;
    pulse_reset();
    wait_pair("w1", d);
    check("w1_dat", d, 32'd0);
    wait_pair("w2", d);
    check("w2_dat", d, 32'hFFFF_FFFF);
    wait_pair("w3", d);
    check("w3_dat", d, 32'hFFFF_FFFE);
    check("w_count", count2, 32'hFFFF_FFFD);
    check("w_err",   {31'd0, err2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
